draw_glyph_object: RTL and testbench
====================================

DRAW_GLYPH_OBJECT -- requirements
Module: draw_glyph_object

Interface
REQ-001 Parameters SHALL be: FG_COLOUR, default 3'b111, colour plotted for set glyph bits; BG_COLOUR, default 3'b000, colour plotted for clear bits (fill build only).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start_draw  input  1  level request from a page controller; held high until draw_object_done is seen.
REQ-005 obj_type  input  5  glyph code, 0-31; letter codes E=17, L=21, P=24, U=27, V=28.
REQ-006 x_origin  input  9  left pixel column of glyph.
REQ-007 y_origin  input  8  top pixel row of glyph.
REQ-008 draw_object_done  output  1  glyph finished; level held while in DONE.
REQ-009 vga_x  output  9  pixel column to plot.
REQ-010 vga_y  output  8  pixel row to plot.
REQ-011 vga_colour  output  3  pixel colour.
REQ-012 vga_plot  output  1  write strobe for vga_x/vga_y/vga_colour.

Function
REQ-013 Glyphs SHALL be 8 wide x 16 tall; screen 320x240; row bit 7 is the leftmost pixel.
REQ-014 FSM states SHALL be IDLE, FETCH, PLOT, DONE.
REQ-015 IDLE: on start_draw=1, latch obj_type/x_origin/y_origin, clear row/col counters, go to FETCH; origin inputs are ignored after this latch.
REQ-016 FETCH: issue ROM address {type,row}; next cycle go to PLOT (1-cycle synchronous ROM latency).
REQ-017 PLOT: one pixel per cycle, col 0..7; after col 7, go to FETCH with row+1, or to DONE if row was 15.
REQ-018 DONE: draw_object_done=1; stay while start_draw=1; go to IDLE on start_draw=0.
REQ-019 Latency: start sampled at edge N; first PLOT cycle N+2; 9 cycles per row; DONE entered at edge N+145; 128 PLOT cycles total.
REQ-020 In PLOT, vga_x=x_lat+col and vga_y=y_lat+row, computed at 10/9 bits before truncation.
REQ-021 Clip: vga_plot=0 when x_lat+col>319 or y_lat+row>239; sums SHALL NOT wrap onto the screen.
REQ-022 Set bit SHALL give vga_plot=1 and vga_colour=FG_COLOUR.
REQ-023 Outside PLOT, vga_plot=0 and vga_colour=0.
REQ-024 start_draw falling mid-draw SHALL be ignored; the glyph completes; DONE then lasts exactly one cycle.
REQ-025 Unassigned codes, including 0, SHALL read all-zero rows; the block still runs the full 145-cycle sequence.
REQ-026 Outputs SHALL be functions of registered state only; no input-to-output combinational path.

Reset
REQ-027 resetn=0 SHALL force IDLE at once, including mid-draw, and zero all counters, latches and outputs.
REQ-028 After release, the first draw SHALL start only on a start_draw sampled high in IDLE.

Configuration
REQ-029 Macro GLYPH_BG_FILL_EN defined: clear bits SHALL plot with vga_plot=1 and BG_COLOUR, giving an opaque 8x16 box; clipping still applies.
REQ-030 Macro undefined: clear bits SHALL give vga_plot=0 (transparent); cycle timing identical in both builds.

Structure
REQ-031 Shared package SHALL hold GLYPH_W=8, GLYPH_H=16, SCREEN_W=320, SCREEN_H=240, glyph type codes and FSM state encodings.
REQ-032 Sub-module glyph_rom SHALL be 512x8 (32 types x 16 rows), with a synchronous read and address {obj_type,row[3:0]}.

Verification
REQ-033 Type 21 (L) at (121,91), start held until done: exactly 145 cycles to done; plotted pixel set equals ROM bitmap offset by (121,91).
REQ-034 Page handshake L1,E1,V,E2,L2,U,P, with a controller dropping start one cycle after done: 7 glyphs drawn; done low on each new start; no missed or extra glyph.
REQ-035 x_origin=316, y_origin=230: no vga_plot with x>319 or y>239; cycle count still 145.
REQ-036 resetn pulsed low at cycle 60 of a draw: outputs zero immediately; IDLE; next start draws a full glyph correctly.
REQ-037 Type 0: zero plots in transparent build; exactly 128 BG_COLOUR plots in GLYPH_BG_FILL_EN build.
REQ-038 start dropped at cycle 40: glyph completes; done high for exactly one cycle; then IDLE.

Source files
------------

// File: rtl/draw_glyph_object_pkg.sv
// Shared constants, glyph codes, FSM encoding and pixel record for draw_glyph_object.
package draw_glyph_object_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam logic [9:0] SCREEN_W = 10'd320;
    localparam logic [8:0] SCREEN_H = 9'd240;

    // Letter codes carried in the glyph ROM; every other code reads blank
    localparam logic [4:0] CODE_E = 5'd17;
    localparam logic [4:0] CODE_L = 5'd21;
    localparam logic [4:0] CODE_P = 5'd24;
    localparam logic [4:0] CODE_U = 5'd27;
    localparam logic [4:0] CODE_V = 5'd28;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLOT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Everything the block drives toward the frame buffer, registered as one word
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
        logic       plot;
        logic       done;
    } pix_t;

endpackage

// File: rtl/draw_glyph_object_if.sv
// Page-controller <-> glyph-drawer handshake plus the VGA pixel write port.
interface draw_glyph_object_if;
    logic       start_draw;
    logic [4:0] obj_type;
    logic [8:0] x_origin;
    logic [7:0] y_origin;
    logic       draw_object_done;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    // Page controller side
    modport master (
        output start_draw, obj_type, x_origin, y_origin,
        input  draw_object_done, vga_x, vga_y, vga_colour, vga_plot
    );

    // Glyph drawer side
    modport slave (
        input  start_draw, obj_type, x_origin, y_origin,
        output draw_object_done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_glyph_object_glyph_rom.sv
// glyph_rom: 512x8 font ROM (32 codes x 16 rows), synchronous read, address {code,row}.
// Row bit 7 is the leftmost pixel. Only E, L, P, U, V carry artwork.
module glyph_rom
    import draw_glyph_object_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] addr,
    output logic [7:0] data
);

    // Blocky 2-pixel-stroke letters occupying rows 2..13
    function automatic logic [7:0] glyph_bits(input logic [4:0] code, input logic [3:0] r);
        logic [7:0] b;
        b = '0;
        if (r >= 4'd2 && r <= 4'd13) begin
            case (code)
                CODE_E:  b = (r == 4'd2 || r == 4'd13) ? 8'h7E : (r == 4'd8) ? 8'h7C : 8'h60;
                CODE_L:  b = (r == 4'd13) ? 8'h7E : 8'h60;
                CODE_P:  b = (r == 4'd2 || r == 4'd7) ? 8'h7C : (r <= 4'd6) ? 8'h66 : 8'h60;
                CODE_U:  b = (r == 4'd13) ? 8'h3C : 8'h66;
                CODE_V:  b = (r == 4'd13) ? 8'h18 : (r == 4'd12) ? 8'h3C : 8'h66;
                default: b = '0;
            endcase
        end
        return b;
    endfunction

    // One-cycle read latency: data reflects the address presented last cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data <= '0;
        else         data <= glyph_bits(addr[8:4], addr[3:0]);
    end

endmodule

// File: rtl/draw_glyph_object.sv
// draw_glyph_object: plots one 8x16 glyph from the font ROM at a latched origin,
// one pixel per cycle, clipping anything past the 320x240 screen.
// Build option: GLYPH_BG_FILL_EN -- clear bits plot in BG_COLOUR (opaque box);
// undefined, clear bits are not plotted (transparent). Timing is identical.
// All outputs come straight from registers.
module draw_glyph_object
    import draw_glyph_object_pkg::*;
#(
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    draw_glyph_object_if.slave   bus
);

    localparam logic [2:0] LAST_COL = 3'(GLYPH_W - 1);
    localparam logic [3:0] LAST_ROW = 4'(GLYPH_H - 1);

    state_t     state, state_nxt;
    logic [4:0] type_lat;
    logic [8:0] x_lat;
    logic [7:0] y_lat;
    logic [3:0] row;
    logic [2:0] col;
    logic [7:0] rom_q;
    logic [9:0] x_sum;
    logic [8:0] y_sum;
    logic       bit_set;
    logic       on_screen;
    pix_t       pix_d, pix_q;

    glyph_rom u_rom (
        .clk    (clk),
        .resetn (resetn),
        .addr   ({type_lat, row}),
        .data   (rom_q)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state: start only matters in IDLE and DONE, so a mid-draw drop is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start_draw) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_PLOT;
            S_PLOT:  if (col == LAST_COL) state_nxt = (row == LAST_ROW) ? S_DONE : S_FETCH;
            S_DONE:  if (!bus.start_draw) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Origin/type latch and row/column counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            type_lat <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start_draw) begin
                    type_lat <= bus.obj_type;
                    x_lat    <= bus.x_origin;
                    y_lat    <= bus.y_origin;
                    row      <= '0;
                    col      <= '0;
                end
                S_FETCH: col <= '0;
                S_PLOT: begin
                    col <= col + 3'd1;
                    if (col == LAST_COL) row <= row + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Pixel decode; sums are one bit wider so off-screen pixels never wrap back on
    always_comb begin
        x_sum     = {1'b0, x_lat} + {7'd0, col};
        y_sum     = {1'b0, y_lat} + {5'd0, row};
        bit_set   = rom_q[3'd7 - col];
        on_screen = (x_sum < SCREEN_W) && (y_sum < SCREEN_H);
        pix_d     = '0;
        if (state == S_PLOT) begin
            pix_d.x      = x_sum[8:0];
            pix_d.y      = y_sum[7:0];
            pix_d.colour = bit_set ? FG_COLOUR : BG_COLOUR;
`ifdef GLYPH_BG_FILL_EN
            pix_d.plot   = on_screen;
`else
            pix_d.plot   = on_screen & bit_set;
`endif
        end
        pix_d.done = (state == S_DONE);
    end

    // Output register: breaks every input-to-output path
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pix_q <= '0;
        else         pix_q <= pix_d;
    end

    assign bus.vga_x            = pix_q.x;
    assign bus.vga_y            = pix_q.y;
    assign bus.vga_colour       = pix_q.colour;
    assign bus.vga_plot         = pix_q.plot;
    assign bus.draw_object_done = pix_q.done;

endmodule

// File: tb/tb_draw_glyph_object.sv
// Self-checking bench for draw_glyph_object: directed page/clip/reset/drop cases
// plus random glyphs, against a pixel-set model built from bitmaps kept here.
module tb_draw_glyph_object;

    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;
`ifdef GLYPH_BG_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    // Bitmaps, row 0 in the top byte
    localparam logic [127:0] BMP_E = 128'h0000_7E60_6060_6060_7C60_6060_607E_0000;
    localparam logic [127:0] BMP_L = 128'h0000_6060_6060_6060_6060_6060_607E_0000;
    localparam logic [127:0] BMP_P = 128'h0000_7C66_6666_667C_6060_6060_6060_0000;
    localparam logic [127:0] BMP_U = 128'h0000_6666_6666_6666_6666_6666_663C_0000;
    localparam logic [127:0] BMP_V = 128'h0000_6666_6666_6666_6666_6666_3C18_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    draw_glyph_object_if bus();

    draw_glyph_object #(.FG_COLOUR(FG), .BG_COLOUR(BG)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_row(input int t, input int r);
        logic [127:0] b;
        case (t)
            17: b = BMP_E;
            21: b = BMP_L;
            24: b = BMP_P;
            27: b = BMP_U;
            28: b = BMP_V;
            default: b = '0;
        endcase
        return b[127 - 8*r -: 8];
    endfunction

    // Draw one glyph as a page controller would; drop_at<0 holds start until done
    task automatic draw(input int t, input int x, input int y, input int drop_at, input string tag);
        int cnt;
        int nbad;
        bit held;
        exp_q.delete();
        obs_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                logic [7:0] rb;
                bit on;
                rb = ref_row(t, r);
                on = rb[7 - c];
                if ((x + c) < 320 && (y + r) < 240 && (on || FILL))
                    exp_q.push_back({9'(x + c), 8'(y + r), on ? FG : BG});
            end
        end
        chk({tag, "_done_lo"}, 32'(bus.draw_object_done), 0);
        bus.start_draw = 1'b1;
        bus.obj_type   = 5'(t);
        bus.x_origin   = 9'(x);
        bus.y_origin   = 8'(y);
        @(posedge clk); #1;
        // Origin inputs must be ignored once latched
        bus.obj_type = 5'($urandom);
        bus.x_origin = 9'($urandom);
        bus.y_origin = 8'($urandom);
        cnt = 0;
        while (cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.vga_plot) obs_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
            if (cnt == drop_at) bus.start_draw = 1'b0;
            if (bus.draw_object_done) break;
        end
        chk({tag, "_cycles"}, 32'(cnt), 145);
        chk({tag, "_nplot"}, 32'(obs_q.size()), 32'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) nbad++;
        chk({tag, "_pixbad"}, 32'(nbad), 0);
        held = bus.start_draw;
        if (held) begin
            @(posedge clk); #1;
            chk({tag, "_done_hold"}, 32'(bus.draw_object_done), 1);
            bus.start_draw = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 32'(bus.draw_object_done), 0);
        chk({tag, "_idle"}, 32'({bus.vga_plot, bus.vga_colour}), 0);
    endtask

    initial begin
        int lett[5] = '{17, 21, 24, 27, 28};
        bus.start_draw = 1'b0;
        bus.obj_type   = '0;
        bus.x_origin   = '0;
        bus.y_origin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.draw_object_done}), 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle", 32'({bus.vga_plot, bus.draw_object_done}), 0);

        draw(21, 121, 91, -1, "L_121_91");

        // Page: L1 E1 V E2 L2 U P
        draw(21, 10, 20, -1, "pg_L1");
        draw(17, 18, 20, -1, "pg_E1");
        draw(28, 26, 20, -1, "pg_V");
        draw(17, 34, 20, -1, "pg_E2");
        draw(21, 42, 20, -1, "pg_L2");
        draw(27, 50, 20, -1, "pg_U");
        draw(24, 58, 20, -1, "pg_P");

        draw(21, 316, 230, -1, "clip");
        draw(28, 508, 200, -1, "xwrap");
        draw(27, 100, 250, -1, "ywrap");

        draw(0, 10, 10, -1, "t0");
        chk("t0_count", 32'(obs_q.size()), FILL ? 32'd128 : 32'd0);

        draw(21, 100, 50, 40, "drop40");

        // Reset in the middle of a draw
        bus.start_draw = 1'b1;
        bus.obj_type   = 5'd21;
        bus.x_origin   = 9'd30;
        bus.y_origin   = 8'd30;
        repeat (61) @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.start_draw = 1'b0;
        #1;
        chk("rst_mid_out", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.draw_object_done}), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_idle", 32'({bus.vga_plot, bus.draw_object_done}), 0);
        end
        draw(24, 200, 100, -1, "post_rst");

        // Random glyphs, origins and start drops
        for (int i = 0; i < 8; i++) begin
            int t, x, y, d;
            t = ($urandom_range(0, 1) == 1) ? lett[$urandom_range(0, 4)] : int'($urandom_range(0, 31));
            x = $urandom_range(0, 511);
            y = $urandom_range(0, 255);
            d = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(5, 140));
            draw(t, x, y, d, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
